neorv32_irq_rst_ctrl: RTL

- Parametrised glue stage between the board/accelerator domain and the neorv32 accelerator SoC core.
- Sequences the core's active-low reset, replacing a direct reset pass-through.
- Conditions N external interrupt sources (sync, level/edge mode, pending, mask) into the single machine-external interrupt.
- Synchronises the timer and software interrupts.
- Small register port lets firmware (via CFS) or the bench read/clear pending bits and set the mask.

---
 rtl/neorv32_irq_rst_pkg.sv | 28 ++
 rtl/neorv32_irq_chan.sv | 50 +++++
 rtl/neorv32_irq_rst_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/neorv32_irq_rst_pkg.sv
// ============================================================================
// Module : neorv32_irq_rst_pkg
// Brief  : Shared FSM encoding, register map and STATUS layout for the
//          neorv32 interrupt / reset glue stage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package neorv32_irq_rst_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_HOLD  = 2'd1,
    ST_RUN   = 2'd2
  } rst_state_t;

  localparam logic [1:0] ADDR_ENABLE   = 2'd0;
  localparam logic [1:0] ADDR_PENDING  = 2'd1;
  localparam logic [1:0] ADDR_STATUS   = 2'd2;
  localparam logic [1:0] ADDR_WDT_KICK = 2'd3;

  localparam int STATUS_STATE_LSB = 0;
  localparam int STATUS_STATE_MSB = 1;
  localparam int STATUS_WDT_BIT   = 2;

endpackage

`default_nettype wire

// File: rtl/neorv32_irq_chan.sv
// ============================================================================
// Module : neorv32_irq_chan
// Brief  : One external interrupt channel: 2-flop sync, edge detect,
//          pending flop with write-one-to-clear for edge channels.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module neorv32_irq_chan #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic irq_raw,
  input  logic clr,
  output logic pending
);

  logic sync1;
  logic sync2;
  logic prev;
  logic rise;

  assign rise = sync2 & ~prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      sync1 <= irq_raw;
      sync2 <= sync1;
      prev  <= sync2;
      if (!run) begin
        pending <= 1'b0;
      end else if (EDGE) begin
        // a fresh edge beats a simultaneous clear
        pending <= rise | (pending & ~clr);
      end else begin
        pending <= sync2;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/neorv32_irq_rst_ctrl.sv
// ============================================================================
// Module : neorv32_irq_rst_ctrl
// Brief  : Core reset sequencer and interrupt conditioning for neorv32.
//          Optional watchdog enabled by defining NEORV32_WDT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module neorv32_irq_rst_ctrl
  import neorv32_irq_rst_pkg::*;
#(
  parameter int          N_IRQ           = 8,
  parameter logic [31:0] IRQ_EDGE_MASK   = 32'h0000_0000,
  parameter int          RST_HOLD_CYCLES = 16,
  parameter int          WDT_WIDTH       = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic             mtime_irq_i,
  input  logic             msw_irq_i,
  input  logic             cfg_we_i,
  input  logic [1:0]       cfg_addr_i,
  input  logic [31:0]      cfg_wdata_i,
  output logic [31:0]      cfg_rdata_o,
  output logic             core_rstn_o,
  output logic             mtime_irq_o,
  output logic             msw_irq_o,
  output logic             mext_irq_o
);

  localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

  rst_state_t        state;
  rst_state_t        state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_next;
  logic              run;
  logic              chan_run;
  logic              wdt_expire;
  logic              wdt_fired;
  logic [N_IRQ-1:0]  enable;
  logic [N_IRQ-1:0]  pending;
  logic [N_IRQ-1:0]  pend_clr;
  logic [1:0]        mtime_sync;
  logic [1:0]        msw_sync;
  logic              unused_wdata;

  assign run          = (state == ST_RUN);
  assign chan_run     = run & ~wdt_expire;
  assign unused_wdata = ^cfg_wdata_i;

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    case (state)
      ST_RESET: begin
        state_next = ST_HOLD;
        hold_next  = '0;
      end
      ST_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_next = ST_RUN;
        end else begin
          hold_next = hold_cnt + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (wdt_expire) begin
          state_next = ST_HOLD;
          hold_next  = '0;
        end
      end
      default: begin
        state_next = ST_RESET;
        hold_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_RESET;
      hold_cnt    <= '0;
      core_rstn_o <= 1'b0;
    end else begin
      state       <= state_next;
      hold_cnt    <= hold_next;
      core_rstn_o <= (state_next == ST_RUN);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_sync <= 2'b00;
      msw_sync   <= 2'b00;
    end else begin
      mtime_sync <= {mtime_sync[0], mtime_irq_i};
      msw_sync   <= {msw_sync[0], msw_irq_i};
    end
  end

  assign mtime_irq_o = mtime_sync[1];
  assign msw_irq_o   = msw_sync[1];

  assign pend_clr = (cfg_we_i && (cfg_addr_i == ADDR_PENDING) && run)
                    ? cfg_wdata_i[N_IRQ-1:0] : '0;

  for (genvar k = 0; k < N_IRQ; k++) begin : g_chan
    neorv32_irq_chan #(
      .EDGE (IRQ_EDGE_MASK[k])
    ) u_chan (
      .clk     (clk_i),
      .rst     (rst_i),
      .run     (chan_run),
      .irq_raw (irq_i[k]),
      .clr     (pend_clr[k]),
      .pending (pending[k])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable     <= '0;
      mext_irq_o <= 1'b0;
    end else begin
      if (!chan_run) begin
        enable <= '0;
      end else if (cfg_we_i && (cfg_addr_i == ADDR_ENABLE)) begin
        enable <= cfg_wdata_i[N_IRQ-1:0];
      end
      mext_irq_o <= |(pending & enable);
    end
  end

`ifdef NEORV32_WDT_EN
  logic [WDT_WIDTH-1:0] wdt_cnt;
  logic                 wdt_kick;

  assign wdt_kick   = cfg_we_i && (cfg_addr_i == ADDR_WDT_KICK);
  assign wdt_expire = run && !wdt_kick && (wdt_cnt == '1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdt_cnt   <= '0;
      wdt_fired <= 1'b0;
    end else begin
      if (!run || wdt_kick) begin
        wdt_cnt <= '0;
      end else begin
        wdt_cnt <= wdt_cnt + WDT_WIDTH'(1);
      end
      if (wdt_expire) begin
        wdt_fired <= 1'b1;
      end
    end
  end
`else
  logic [WDT_WIDTH-1:0] unused_wdt;

  assign unused_wdt = '0;
  assign wdt_expire = 1'b0;
  assign wdt_fired  = 1'b0;
`endif

  always_comb begin
    cfg_rdata_o = '0;
    case (cfg_addr_i)
      ADDR_ENABLE:  cfg_rdata_o[N_IRQ-1:0] = enable;
      ADDR_PENDING: cfg_rdata_o[N_IRQ-1:0] = pending;
      ADDR_STATUS: begin
        cfg_rdata_o[STATUS_STATE_MSB:STATUS_STATE_LSB] = state;
        cfg_rdata_o[STATUS_WDT_BIT]                    = wdt_fired;
      end
      default: cfg_rdata_o = '0;
    endcase
  end

endmodule

`default_nettype wire
